exc_irq_arbiter: RTL and testbench

//  Arbitrates interrupt lines and decoder exceptions into the single exc_req/exc_ack handshake of the core controller.
//  - Synchronises IRQ inputs, keeps pending state and masks lines.
//  - Selects one source: sync exceptions first, then IRQs round-robin.
//  - Holds the request until ack and supplies cause; tracks handler occupancy until eret.

---
 rtl/exc_irq_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_exc_irq_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_irq_arbiter.sv
// Merges synchronised interrupt lines and decoder exceptions into one exc_req/exc_ack handshake.
// Sync exceptions win over IRQs; IRQs are picked round-robin.
module exc_irq_arbiter #(
  parameter int unsigned        NUM_IRQ       = 8,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE_MASK = '0,
  parameter int unsigned        SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_mask_i,
  input  logic               irq_glob_en_i,
  input  logic               instr_valid_i,
  input  logic               illegal_insn_i,
  input  logic               ebrk_insn_i,
  input  logic               ecall_insn_i,
  input  logic               exc_ack_i,
  input  logic               eret_i,
  output logic               exc_req_o,
  output logic [5:0]         exc_cause_o,
  output logic [NUM_IRQ-1:0] irq_claim_o,
  output logic               in_handler_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StReqSync = 2'd1;
  localparam logic [1:0] StReqIrq  = 2'd2;
  localparam logic [1:0] StHandler = 2'd3;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] irq_s_prev_q;
  logic [NUM_IRQ-1:0] edge_pend_q, edge_pend_d;
  logic [NUM_IRQ-1:0] claim_clr;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] id_oh;
  logic [NUM_IRQ-1:0] claim_q, claim_d;

  logic [1:0] state_q, state_d;
  logic       req_q, req_d;
  logic [5:0] cause_q, cause_d;
  logic [4:0] id_q, id_d;
  logic [4:0] rr_q, rr_d;
  logic       in_hdl_q, in_hdl_d;

  logic       sync_exc;
  logic [4:0] sync_code;
  logic       hi_valid, lo_valid, pick_valid;
  logic [4:0] hi_id, lo_id, pick_id;

  // Synchroniser chain; irq_s is the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= irq_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign irq_s = sync_q[SYNC_STAGES-1];

  // A new rising edge overrides a claim clearing the same bit.
  assign edge_pend_d = (edge_pend_q & ~claim_clr) | (irq_s & ~irq_s_prev_q);
  assign pending     = (IRQ_EDGE_MASK & edge_pend_q) | (~IRQ_EDGE_MASK & irq_s);
  assign eligible    = in_hdl_q ? '0 : (pending & irq_mask_i & {NUM_IRQ{irq_glob_en_i}});

  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) id_oh[i] = (id_q == 5'(i));
  end

  // Round-robin pick: lowest eligible index >= rr_q, else lowest eligible overall.
  always_comb begin
    hi_valid = 1'b0;
    hi_id    = '0;
    lo_valid = 1'b0;
    lo_id    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_valid = 1'b1;
        lo_id    = 5'(i);
        if (5'(i) >= rr_q) begin
          hi_valid = 1'b1;
          hi_id    = 5'(i);
        end
      end
    end
    pick_valid = lo_valid;
    pick_id    = hi_valid ? hi_id : lo_id;
  end

  assign sync_exc  = instr_valid_i & (illegal_insn_i | ebrk_insn_i | ecall_insn_i);
  assign sync_code = illegal_insn_i ? 5'h02 : (ebrk_insn_i ? 5'h03 : 5'h0B);

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    id_d      = id_q;
    rr_d      = rr_q;
    in_hdl_d  = in_hdl_q;
    claim_d   = '0;
    claim_clr = '0;
    unique case (state_q)
      StIdle: begin
        if (sync_exc) begin
          state_d  = StReqSync;
          cause_d  = {1'b0, sync_code};
          in_hdl_d = 1'b0;
        end else if (pick_valid) begin
          state_d = StReqIrq;
          id_d    = pick_id;
          cause_d = {1'b1, pick_id};
        end
      end
      StReqSync: begin
        if (exc_ack_i) begin
          state_d  = StHandler;
          in_hdl_d = 1'b1;
        end
      end
      StReqIrq: begin
        // The ack accepts the cause already presented, so it beats preemption.
        if (exc_ack_i) begin
          state_d   = StHandler;
          in_hdl_d  = 1'b1;
          claim_d   = id_oh;
          claim_clr = id_oh;
          rr_d      = (id_q == 5'(NUM_IRQ - 1)) ? 5'd0 : id_q + 5'd1;
        end else if (sync_exc) begin
          state_d = StReqSync;
          cause_d = {1'b0, sync_code};
        end else if (!(|(eligible & id_oh))) begin
          state_d = StIdle;
        end
      end
      StHandler: begin
        if (sync_exc) begin
          state_d = StReqSync;
          cause_d = {1'b0, sync_code};
        end else if (eret_i) begin
          state_d  = StIdle;
          in_hdl_d = 1'b0;
        end
      end
      default: begin
        state_d  = StIdle;
        in_hdl_d = 1'b0;
      end
    endcase
    req_d = (state_d == StReqSync) || (state_d == StReqIrq);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      cause_q      <= '0;
      id_q         <= '0;
      rr_q         <= '0;
      in_hdl_q     <= 1'b0;
      claim_q      <= '0;
      edge_pend_q  <= '0;
      irq_s_prev_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      cause_q      <= cause_d;
      id_q         <= id_d;
      rr_q         <= rr_d;
      in_hdl_q     <= in_hdl_d;
      claim_q      <= claim_d;
      edge_pend_q  <= edge_pend_d;
      irq_s_prev_q <= irq_s;
    end
  end

  assign exc_req_o    = req_q;
  assign exc_cause_o  = cause_q;
  assign irq_claim_o  = claim_q;
  assign in_handler_o = in_hdl_q;

endmodule

// File: tb/tb_exc_irq_arbiter.sv
// Directed and random stimulus for exc_irq_arbiter, checked every cycle against a behavioural model.
module tb_exc_irq_arbiter;

  localparam int N = 8;
  localparam int S = 2;
  localparam logic [N-1:0] EM = 8'h10;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_i, irq_mask_i;
  logic         irq_glob_en_i, instr_valid_i, illegal_insn_i, ebrk_insn_i, ecall_insn_i;
  logic         exc_ack_i, eret_i;
  logic         exc_req_o;
  logic [5:0]   exc_cause_o;
  logic [N-1:0] irq_claim_o;
  logic         in_handler_o;

  int vectors = 0;
  int miscompares = 0;

  exc_irq_arbiter #(
    .NUM_IRQ      (N),
    .IRQ_EDGE_MASK(EM),
    .SYNC_STAGES  (S)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_i         (irq_i),
    .irq_mask_i    (irq_mask_i),
    .irq_glob_en_i (irq_glob_en_i),
    .instr_valid_i (instr_valid_i),
    .illegal_insn_i(illegal_insn_i),
    .ebrk_insn_i   (ebrk_insn_i),
    .ecall_insn_i  (ecall_insn_i),
    .exc_ack_i     (exc_ack_i),
    .eret_i        (eret_i),
    .exc_req_o     (exc_req_o),
    .exc_cause_o   (exc_cause_o),
    .irq_claim_o   (irq_claim_o),
    .in_handler_o  (in_handler_o)
  );

  always #5 clk = ~clk;

  // Reference model: request/handler booleans plus a history queue of raw irq samples.
  logic [N-1:0] m_hist [S];
  logic [N-1:0] m_prev, m_epend, m_claim;
  int           m_rr, m_id;
  bit           m_req, m_isirq, m_hdl;
  logic [5:0]   m_cause;

  task automatic m_reset();
    for (int i = 0; i < S; i++) m_hist[i] = '0;
    m_prev = '0; m_epend = '0; m_claim = '0;
    m_rr = 0; m_id = 0;
    m_req = 0; m_isirq = 0; m_hdl = 0;
    m_cause = '0;
  endtask

  task automatic m_step();
    logic [N-1:0] irq_s, pend, elig, clr;
    bit           sx;
    logic [4:0]   code;
    int           pick, j;
    irq_s = m_hist[S-1];
    pend  = (irq_s & ~EM) | (m_epend & EM);
    elig  = m_hdl ? '0 : (pend & irq_mask_i & (irq_glob_en_i ? {N{1'b1}} : '0));
    sx    = instr_valid_i && (illegal_insn_i || ebrk_insn_i || ecall_insn_i);
    code  = illegal_insn_i ? 5'd2 : (ebrk_insn_i ? 5'd3 : 5'd11);
    pick  = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_rr + k) % N;
      if (pick < 0 && elig[j[2:0]]) pick = j;
    end
    clr = '0;
    m_claim = '0;
    if (m_req && m_isirq) begin
      if (exc_ack_i) begin
        m_req = 0; m_hdl = 1;
        m_claim = N'(1 << m_id);
        clr = m_claim;
        m_rr = (m_id + 1) % N;
      end else if (sx) begin
        m_isirq = 0; m_cause = {1'b0, code};
      end else if (!elig[m_id[2:0]]) begin
        m_req = 0;
      end
    end else if (m_req) begin
      if (exc_ack_i) begin
        m_req = 0; m_hdl = 1;
      end
    end else if (m_hdl) begin
      if (sx) begin
        m_req = 1; m_isirq = 0; m_cause = {1'b0, code};
      end else if (eret_i) begin
        m_hdl = 0;
      end
    end else begin
      if (sx) begin
        m_req = 1; m_isirq = 0; m_cause = {1'b0, code};
      end else if (pick >= 0) begin
        m_req = 1; m_isirq = 1; m_id = pick; m_cause = 6'(32 + pick);
      end
    end
    m_epend = (m_epend & ~clr) | (irq_s & ~m_prev);
    m_prev  = irq_s;
    for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = irq_i;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_chk();
    chk("m_req", 32'(exc_req_o), 32'(m_req));
    chk("m_hdl", 32'(in_handler_o), 32'(m_hdl));
    chk("m_claim", 32'(irq_claim_o), 32'(m_claim));
    if (m_req) chk("m_cause", 32'(exc_cause_o), 32'(m_cause));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) m_reset();
    else m_step();
    #1;
    model_chk();
  endtask

  task automatic wait_req(input string tag, input int max);
    int n = 0;
    while (!exc_req_o && n < max) begin
      cyc();
      n++;
    end
    chk(tag, 32'(exc_req_o), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic ack_once();
    exc_ack_i = 1'b1;
    cyc();
    exc_ack_i = 1'b0;
  endtask

  task automatic eret_once();
    eret_i = 1'b1;
    cyc();
    eret_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    irq_i = '0; irq_mask_i = '0; irq_glob_en_i = 1'b0;
    instr_valid_i = 1'b0; illegal_insn_i = 1'b0; ebrk_insn_i = 1'b0; ecall_insn_i = 1'b0;
    exc_ack_i = 1'b0; eret_i = 1'b0;
    m_reset();
    #1;
    chk("rst_req", 32'(exc_req_o), 32'd0);
    chk("rst_cause", 32'(exc_cause_o), 32'd0);
    chk("rst_claim", 32'(irq_claim_o), 32'd0);
    chk("rst_hdl", 32'(in_handler_o), 32'd0);
    do_reset();

    // Level line 2: request SYNC_STAGES+1 cycles later
    irq_i = 8'h04; irq_mask_i = 8'hFF; irq_glob_en_i = 1'b1;
    cyc();
    cyc();
    chk("lat_early", 32'(exc_req_o), 32'd0);
    cyc();
    chk("lat_req", 32'(exc_req_o), 32'd1);
    chk("lat_cause", 32'(exc_cause_o), 32'h22);
    ack_once();
    chk("claim_04", 32'(irq_claim_o), 32'h04);
    chk("hdl_after_ack", 32'(in_handler_o), 32'd1);
    cyc();
    chk("claim_pulse", 32'(irq_claim_o), 32'h00);
    irq_i = '0;
    eret_once();
    repeat (3) cyc();

    // Round-robin with lines 0 and 7 held
    do_reset();
    irq_i = 8'h81;
    wait_req("rr1_req", 8);
    chk("rr1_cause", 32'(exc_cause_o), 32'h20);
    ack_once();
    eret_once();
    wait_req("rr2_req", 8);
    chk("rr2_cause", 32'(exc_cause_o), 32'h27);
    ack_once();
    eret_once();
    wait_req("rr3_req", 8);
    chk("rr3_cause", 32'(exc_cause_o), 32'h20);
    ack_once();
    eret_once();

    // Sync exception preempts a pending IRQ request
    wait_req("pre_req", 8);
    instr_valid_i = 1'b1; illegal_insn_i = 1'b1;
    cyc();
    instr_valid_i = 1'b0; illegal_insn_i = 1'b0;
    chk("pre_still_req", 32'(exc_req_o), 32'd1);
    chk("pre_cause", 32'(exc_cause_o), 32'h02);
    ack_once();
    chk("pre_no_claim", 32'(irq_claim_o), 32'h00);
    chk("pre_hdl", 32'(in_handler_o), 32'd1);
    irq_i = '0;
    repeat (3) cyc();
    eret_once();

    // Level withdrawal without claim
    irq_i = 8'h01;
    wait_req("lvl_req", 8);
    irq_i = '0;
    for (int n = 0; n < 6 && exc_req_o; n++) cyc();
    chk("lvl_withdraw", 32'(exc_req_o), 32'd0);
    repeat (2) cyc();

    // Edge line pulsed one cycle stays requested
    irq_i = 8'h10;
    cyc();
    irq_i = '0;
    wait_req("edge_req", 8);
    chk("edge_cause", 32'(exc_cause_o), 32'h24);
    repeat (5) cyc();
    chk("edge_hold", 32'(exc_req_o), 32'd1);
    ack_once();
    chk("edge_claim", 32'(irq_claim_o), 32'h10);

    // No IRQ requests inside the handler; ecall beats eret
    irq_i = 8'hFF;
    for (int n = 0; n < 6; n++) begin
      cyc();
      chk("hdl_block", 32'(exc_req_o), 32'd0);
    end
    eret_i = 1'b1; instr_valid_i = 1'b1; ecall_insn_i = 1'b1;
    cyc();
    eret_i = 1'b0; instr_valid_i = 1'b0; ecall_insn_i = 1'b0;
    chk("ecall_req", 32'(exc_req_o), 32'd1);
    chk("ecall_cause", 32'(exc_cause_o), 32'h0B);
    chk("ecall_hdl", 32'(in_handler_o), 32'd1);
    ack_once();
    eret_once();

    // Asynchronous reset mid-request
    wait_req("arst_pre", 8);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(exc_req_o), 32'd0);
    chk("arst_cause", 32'(exc_cause_o), 32'd0);
    chk("arst_claim", 32'(irq_claim_o), 32'd0);
    chk("arst_hdl", 32'(in_handler_o), 32'd0);
    m_reset();
    cyc();
    rst = 1'b0;
    wait_req("arst_reseen", 8);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) irq_i = N'($urandom);
      if ($urandom_range(15) == 0) irq_mask_i = N'($urandom);
      irq_glob_en_i  = ($urandom_range(9) != 0);
      instr_valid_i  = ($urandom_range(7) == 0);
      illegal_insn_i = ($urandom_range(2) == 0);
      ebrk_insn_i    = ($urandom_range(2) == 0);
      ecall_insn_i   = ($urandom_range(2) == 0);
      exc_ack_i      = ($urandom_range(2) == 0);
      eret_i         = ($urandom_range(7) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
